microtile_bus_arbiter: RTL

Round-robin burst arbiter that shares one 8-bit output bus (the tile's `uo_out` path) between up to four internal requesters inside a microtile Wokwi/TinyTapeout design. Each requester raises a request, receives a one-hot grant, and streams beats until it marks the last one, hits the burst limit, or abandons the request. The block registers the winning requester's data onto the shared bus. It sits between the tile's functional sub-blocks and the `uo_out` driver.

---
 rtl/microtile_bus_arbiter_if.sv | 26 ++
 rtl/microtile_bus_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/microtile_bus_arbiter_if.sv
// rtl/microtile_bus_arbiter_if.sv - requester and shared-bus signal bundle for the microtile bus arbiter
interface microtile_bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       bus_out;
  logic                bus_valid;
  logic [1:0]          bus_owner;
  logic                busy;
  logic                abort;
  logic                trunc;

  modport master (
    output req, last, data,
    input  gnt, bus_out, bus_valid, bus_owner, busy, abort, trunc
  );

  modport slave (
    input  req, last, data,
    output gnt, bus_out, bus_valid, bus_owner, busy, abort, trunc
  );
endinterface

// File: rtl/microtile_bus_arbiter.sv
// rtl/microtile_bus_arbiter.sv - round-robin burst arbiter sharing one registered bus among requesters
module microtile_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microtile_bus_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t           state, state_d;
  logic [1:0]       ptr, ptr_d;
  logic [1:0]       owner, owner_d;
  logic [3:0]       beat_cnt, beat_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]    bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [1:0]       bus_owner_q, bus_owner_d;
  logic             abort_q, abort_d;
  logic             trunc_q, trunc_d;

  logic [1:0]       pick, cand;
  logic             found;
  logic             own_req, own_last;
  logic [DW-1:0]    own_data;

  assign own_req  = arb.req[owner];
  assign own_last = arb.last[owner];
  assign own_data = arb.data[int'(owner)*DW +: DW];

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = 2'((int'(ptr) + k) % N_REQ);
      if (!found && arb.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    beat_cnt_d  = beat_cnt;
    gnt_d       = gnt_q;
    bus_out_d   = '0;
    bus_valid_d = 1'b0;
    bus_owner_d = bus_owner_q;
    abort_d     = 1'b0;
    trunc_d     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_d    = XFER;
          owner_d    = pick;
          gnt_d      = N_REQ'(1) << pick;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (own_req) begin
          bus_out_d   = own_data;
          bus_valid_d = 1'b1;
          bus_owner_d = owner;
          beat_cnt_d  = beat_cnt + 4'd1;
          // last wins over the burst limit when both land on one beat
          if (own_last || beat_cnt_d == 4'(MAX_BURST)) begin
            state_d = GAP;
            gnt_d   = '0;
            trunc_d = !own_last;
          end
        end else begin
          state_d = GAP;
          gnt_d   = '0;
          abort_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        ptr_d   = (int'(owner) == N_REQ - 1) ? 2'd0 : owner + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      gnt_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_owner_q <= '0;
      abort_q     <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      owner       <= owner_d;
      beat_cnt    <= beat_cnt_d;
      gnt_q       <= gnt_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_owner_q <= bus_owner_d;
      abort_q     <= abort_d;
      trunc_q     <= trunc_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.bus_out   = bus_out_q;
  assign arb.bus_valid = bus_valid_q;
  assign arb.bus_owner = bus_owner_q;
  assign arb.busy      = (state != IDLE);
  assign arb.abort     = abort_q;
  assign arb.trunc     = trunc_q;
endmodule
